// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU MEM stage (port 0)
// and the loader/debug port (port 1). Port 0 has fixed priority. A
// starvation counter forces a port-1 grant after STARVE_LIMIT consecutive
// denials. Read data returns in a register one cycle after the grant.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              m1_starved
);

  // Counter value at which one more denial arms the forced grant.
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        m1_starved_reg, m1_starved_next;
  logic [1:0]  gnt_vec, we_vec, rvalid_vec;
  logic [31:0] rdata_vec [2];

  // Single-winner grant: pending starvation beats port 0, port 0 beats port 1.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m1_starved_reg && m1_req) begin
        m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  // Memory-side mux; idle cycles present port 0 so the bus never floats.
  always_comb begin
    mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  end

  // Count consecutive port-1 denials; any grant or withdrawal starts over.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    m1_starved_next = m1_starved_reg;
    if (m1_req && !m1_gnt) begin
      if (starve_cnt_reg != 4'hF) begin
        starve_cnt_next = starve_cnt_reg + 4'd1;
      end
      if (starve_cnt_reg >= LIMIT_M1) begin
        m1_starved_next = 1'b1;
      end
    end else begin
      starve_cnt_next = 4'd0;
      m1_starved_next = 1'b0;
    end
  end

  // Starvation state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_reg <= 4'd0;
      m1_starved_reg <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      m1_starved_reg <= m1_starved_next;
    end
  end

  assign gnt_vec = {m1_gnt, m0_gnt};
  assign we_vec  = {m1_we, m0_we};

  // One identical read-response register pair per port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic        rd_hit;

    assign rd_hit = gnt_vec[gi] & ~we_vec[gi];

    // Capture memory data on a granted read; rdata holds across writes/idle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= 32'd0;
      end else begin
        rvalid_reg <= rd_hit;
        if (rd_hit) begin
          rdata_reg <= mem_rdata;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign rdata_vec[gi]  = rdata_reg;
  end

  assign m0_rvalid  = rvalid_vec[0];
  assign m0_rdata   = rdata_vec[0];
  assign m1_rvalid  = rvalid_vec[1];
  assign m1_rdata   = rdata_vec[1];
  assign m1_starved = m1_starved_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level
// model (denial count, shadow memory, pending read responses).
module tb_dmem_arbiter;

  localparam int LIMIT = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_we, m1_starved;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  // External memory: combinational read, synchronous write.
  logic [31:0] ram [0:1023];
  assign mem_rdata = ram[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .m1_starved(m1_starved)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] shadow [0:1023];
  int          denials = 0;          // consecutive cycles port 1 asked and lost
  logic        exp_rvalid [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rdata  [2] = '{32'd0, 32'd0};
  bit          mon_en = 1'b0;

  // Who wins this cycle: -1 none, 0 or 1.
  function automatic int model_winner();
    if (!rst_n) return -1;
    if (m1_req && denials >= LIMIT) return 1;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  // Compare every cycle, then advance the model across the coming edge.
  initial begin
    int w;
    logic [31:0] a, d;
    logic we;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        w = model_winner();
        a  = (w == 1) ? m1_addr  : m0_addr;
        d  = (w == 1) ? m1_wdata : m0_wdata;
        we = (w == 1) ? m1_we : (w == 0) ? m0_we : 1'b0;
        chk("m0_gnt",     m0_gnt, (w == 0));
        chk("m1_gnt",     m1_gnt, (w == 1));
        chk("mem_we",     mem_we, we);
        chk("mem_addr",   mem_addr, a);
        chk("mem_wdata",  mem_wdata, d);
        chk("m1_starved", m1_starved, (denials >= LIMIT));
        chk("m0_rvalid",  m0_rvalid, exp_rvalid[0]);
        chk("m0_rdata",   m0_rdata, exp_rdata[0]);
        chk("m1_rvalid",  m1_rvalid, exp_rvalid[1]);
        chk("m1_rdata",   m1_rdata, exp_rdata[1]);
        if (w >= 0)
          $display("txn t=%0t port=%0d %s addr=%h data=%h", $time, w,
                   we ? "WR" : "RD", a, we ? d : shadow[a[11:2]]);
        if (!rst_n) begin
          denials = 0;
          exp_rvalid[0] = 1'b0; exp_rvalid[1] = 1'b0;
          exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
        end else begin
          exp_rvalid[0] = 1'b0; exp_rvalid[1] = 1'b0;
          if (w >= 0) begin
            if (we) shadow[a[11:2]] = d;
            else begin
              exp_rvalid[w] = 1'b1;
              exp_rdata[w]  = shadow[a[11:2]];
            end
          end
          if (m1_req && w != 1) denials++;
          else denials = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic new_req(input int rate, output logic r, output logic w,
                         output logic [31:0] a, output logic [31:0] d);
    logic [31:0] x;
    r = ($urandom_range(0, 99) < rate);
    w = $urandom_range(0, 1) == 1;
    x = $urandom;
    a = (x & 32'hFFFF_F000) | ({28'd0, x[3:0]} << 2);
    d = $urandom;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic g0, g1;
    logic [31:0] pat;
    static bit seq_req [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    static bit seq_gnt [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'hA500_0000 | i;
      shadow[i] = 32'hA500_0000 | i;
    end
    ram[4] = 32'hDEAD_BEEF;
    shadow[4] = 32'hDEAD_BEEF;

    rst_n = 1'b0; idle();
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst m0_rvalid", m0_rvalid, 0);
    chk("rst m1_rvalid", m1_rvalid, 0);
    chk("rst m0_rdata", m0_rdata, 0);
    chk("rst m1_starved", m1_starved, 0);
    chk("rst m0_gnt", m0_gnt, 0);

    // Simple read of 0x10.
    step(); rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk); chk("rd10 m0_gnt", m0_gnt, 1);
    step(); idle();
    @(negedge clk);
    chk("rd10 m0_rvalid", m0_rvalid, 1);
    chk("rd10 m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd10 m1_rvalid", m1_rvalid, 0);
    chk("rd10 m1_rdata", m1_rdata, 0);

    // Both ports saturating: 4 x port 0, 1 x port 1, repeating.
    step(); idle();
    for (int i = 0; i < 10; i++) begin
      step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
      @(negedge clk);
      chk("rr m1_gnt", m1_gnt, (i % 5 == 4));
      chk("rr m0_gnt", m0_gnt, (i % 5 != 4));
      chk("rr m1_starved", m1_starved, (i % 5 == 4));
    end

    // Port-1 write then port-0 read of the same word.
    step(); idle();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678;
    @(negedge clk); chk("wr40 mem_we", mem_we, 1);
    step(); idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    @(negedge clk); chk("rd40 m0_gnt", m0_gnt, 1);
    step(); idle();
    @(negedge clk); chk("rd40 m0_rdata", m0_rdata, 32'h1234_5678);

    // Withdrawal of m1_req restarts the denial count.
    step(); idle();
    for (int i = 0; i < 9; i++) begin
      step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
      m1_req = seq_req[i]; m1_we = 1'b0; m1_addr = 32'hC;
      @(negedge clk); chk("abort m1_gnt", m1_gnt, seq_gnt[i]);
    end

    // Reset with a forced grant pending and a port-0 write presented.
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
      @(negedge clk); chk("pre m1_gnt", m1_gnt, 0);
    end
    step(); rst_n = 1'b0;
    m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rstwr mem_we", mem_we, 0);
    chk("rstwr m0_gnt", m0_gnt, 0);
    chk("rstwr m1_gnt", m1_gnt, 0);
    step(); rst_n = 1'b1; idle();
    @(negedge clk);
    chk("postrst m0_rvalid", m0_rvalid, 0);
    chk("postrst m1_starved", m1_starved, 0);
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
    step(); idle();
    @(negedge clk);
    chk("rd80 m0_rvalid", m0_rvalid, 1);
    chk("rd80 m0_rdata", m0_rdata, 32'hA500_0020);

    // Back-to-back reads of words 0,1,2.
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      step();
      m0_req = (i < 3); m0_we = 1'b0; m0_addr = i * 4;
      @(negedge clk);
      if (i > 0) begin
        chk("b2b m0_rvalid", m0_rvalid, 1);
        pat = 32'hA500_0000 | (i - 1);
        chk("b2b m0_rdata", m0_rdata, pat);
      end
    end
    step(); idle();
    @(negedge clk); chk("b2b fall", m0_rvalid, 0);

    // Randomized traffic obeying the hold rule, with occasional resets.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      step();
      rst_n = ($urandom_range(0, 99) != 0);
      if (!m0_req || g0) new_req(80, m0_req, m0_we, m0_addr, m0_wdata);
      else if ($urandom_range(0, 99) < 3) m0_req = 1'b0;
      if (!m1_req || g1) new_req(60, m1_req, m1_we, m1_addr, m1_wdata);
      else if ($urandom_range(0, 99) < 3) m1_req = 1'b0;
    end

    step(); rst_n = 1'b1; idle();
    step(); step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
